// File: rtl/addsub_accum_unit.sv
// Registered N-bit add/subtract unit with accumulator, valid/ready handshakes and sticky overflow.
// Define ADDSUB_SATURATE_EN to saturate results (and accumulator) on signed overflow.
module addsub_accum_unit #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  input  logic [1:0]   op,
  input  logic         clr,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] s,
  output logic         c_out,
  output logic         overflow,
  output logic         ovf_sticky,
  output logic [N-1:0] acc
);

  logic [N-1:0] r_s;
  logic         r_c_out;
  logic         r_overflow;
  logic         r_out_valid;
  logic [N-1:0] r_acc;
  logic         r_ovf_sticky;

  logic         w_accept;
  logic [N-1:0] w_a;
  logic [N-1:0] w_b;
  logic [N:0]   w_sum;
  logic         w_ovf;
  logic [N-1:0] w_res;

  // Handshake: a transfer happens on a rising edge where valid & ready are both high.
  // Input side may accept whenever the output slot is empty or is being drained this cycle.
  assign in_ready = ~r_out_valid | out_ready;
  assign w_accept = in_valid & in_ready;

  // A clear in the same cycle as an accumulate op makes that op start from zero.
  assign w_a   = op[1] ? (clr ? '0 : r_acc) : x;
  assign w_b   = y ^ {N{op[0]}};
  assign w_sum = {1'b0, w_a} + {1'b0, w_b} + {{N{1'b0}}, op[0]};
  assign w_ovf = (w_a[N-1] & w_b[N-1] & ~w_sum[N-1]) |
                 (~w_a[N-1] & ~w_b[N-1] & w_sum[N-1]);

`ifdef ADDSUB_SATURATE_EN
  always_comb begin
    w_res = w_sum[N-1:0];
    if (w_ovf) w_res = w_a[N-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
  end
`else
  assign w_res = w_sum[N-1:0];
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_s          <= '0;
      r_c_out      <= 1'b0;
      r_overflow   <= 1'b0;
      r_out_valid  <= 1'b0;
      r_acc        <= '0;
      r_ovf_sticky <= 1'b0;
    end else begin
      if (w_accept) begin
        r_s         <= w_res;
        r_c_out     <= w_sum[N];
        r_overflow  <= w_ovf;
        r_out_valid <= 1'b1;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end

      if (w_accept && op[1]) r_acc <= w_res;
      else if (clr)          r_acc <= '0;

      if (w_accept)  r_ovf_sticky <= (clr ? 1'b0 : r_ovf_sticky) | w_ovf;
      else if (clr)  r_ovf_sticky <= 1'b0;
    end
  end

  assign s          = r_s;
  assign c_out      = r_c_out;
  assign overflow   = r_overflow;
  assign out_valid  = r_out_valid;
  assign acc        = r_acc;
  assign ovf_sticky = r_ovf_sticky;

endmodule
